uart_tx_mmio: RTL

- Memory-mapped UART transmitter on the core's data-memory port, beside the data RAM.
- Consumes the core's store and load requests for its own address window.
- Buffers bytes in a small FIFO and serialises them as 8N1 frames on txd.
- Adds the first output device to the SoC; the top-level ties its request inputs in parallel with the RAM, qualified by address.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_tx_mmio.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, STATUS layout and TX FSM states for the MMIO UART
package uart_pkg;

  localparam logic [1:0] TXDATA_OFS = 2'd0;
  localparam logic [1:0] STATUS_OFS = 2'd1;
  localparam logic [1:0] BAUD_OFS   = 2'd2;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_COUNT_LSB = 7;
  localparam int ST_COUNT_W   = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push into a full FIFO is accepted only alongside a pop
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Pointers are PTR_W wide, so DEPTH being a power of two gives the wrap for free.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO on the data-memory port
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren,
  input  logic [31:0] r_addr_i,
  output logic [31:0] r_data_o,
  input  logic [3:0]  wen,
  input  logic [31:0] w_addr_i,
  input  logic [31:0] w_data_i,
  output logic        txd,
  output logic        tx_irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_t   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_q, div_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] baud_div_q, baud_div_d;
  logic        txd_q, txd_d;
  logic        irq_q, irq_d;
  logic        ovf_q, ovf_d;

  logic             r_hit, w_hit;
  logic [1:0]       r_ofs, w_ofs;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_data;
  logic [CNT_W-1:0] fifo_count;
  logic [15:0]      eff_div;
  logic             unused_bits;

  assign r_hit   = (r_addr_i[31:4] == BASE_ADDR[31:4]);
  assign w_hit   = (w_addr_i[31:4] == BASE_ADDR[31:4]);
  assign r_ofs   = r_addr_i[3:2];
  assign w_ofs   = w_addr_i[3:2];
  assign push    = w_hit && (w_ofs == TXDATA_OFS) && wen[0];
  assign pop     = (state_q == IDLE) && !fifo_empty;
  assign eff_div = (baud_div_q == 16'd0) ? 16'd1 : baud_div_q;

  assign txd    = txd_q;
  assign tx_irq = irq_q;

  assign unused_bits = ^{r_addr_i[1:0], w_addr_i[1:0], wen[3:2], w_data_i[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (w_data_i[7:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    r_data_o = '0;
    if (ren && r_hit) begin
      case (r_ofs)
        STATUS_OFS: begin
          r_data_o[ST_BUSY_BIT]                   = (state_q != IDLE);
          r_data_o[ST_FULL_BIT]                   = fifo_full;
          r_data_o[ST_EMPTY_BIT]                  = fifo_empty;
          r_data_o[ST_OVF_BIT]                    = ovf_q;
          r_data_o[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
        end
        BAUD_OFS: r_data_o = {16'h0000, baud_div_q};
        default:  r_data_o = '0;
      endcase
    end
  end

  // A dropped push sets overflow even if the same store cycle carries a clear.
  always_comb begin
    baud_div_d = baud_div_q;
    ovf_d      = ovf_q;
    if (w_hit && (w_ofs == BAUD_OFS)) begin
      if (wen[0]) baud_div_d[7:0]  = w_data_i[7:0];
      if (wen[1]) baud_div_d[15:8] = w_data_i[15:8];
    end
    if (w_hit && (w_ofs == STATUS_OFS) && wen[0] && w_data_i[ST_OVF_BIT]) begin
      ovf_d = 1'b0;
    end
    if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_d      = div_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    txd_d      = 1'b1;
    irq_d      = fifo_empty && (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d    = fifo_data;
          div_d      = eff_div;
          baud_cnt_d = eff_div - 16'd1;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_cnt_q == '0) begin
          baud_cnt_d = div_q - 16'd1;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_cnt_q == '0) begin
          baud_cnt_d = div_q - 16'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // txd is registered from the next state so the line never glitches.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      div_q      <= 16'd1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      baud_div_q <= DEFAULT_DIV;
      txd_q      <= 1'b1;
      irq_q      <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_div_q <= baud_div_d;
      txd_q      <= txd_d;
      irq_q      <= irq_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
